alu_issue_ctrl: RTL and testbench

// Issue/writeback sequencer on the driving side of the ALU operand interface (Cond, Op_C,
// Reg1, Reg2, Ld_Sh in; dest_reg and NZCV flags out). Accepts 16-bit instructions over a

---
 rtl/alu_issue_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer driving the ALU operand interface.
// Four-cycle instruction flow: accept, operand read, ALU execute, conditional writeback.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [1:0]        alu_cond,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_reg1,
  output logic [DATA_W-1:0] alu_reg2,
  output logic [6:0]        alu_ld_sh,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic [3:0]        flags_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [15:0]         ir_r;
  logic [15:0]         ir_nxt_s;
  logic [DATA_W-1:0]   regs_r [NREGS];

  logic                instr_ready_r, instr_ready_nxt_s;
  logic [1:0]          alu_cond_r, alu_cond_nxt_s;
  logic [3:0]          alu_op_r, alu_op_nxt_s;
  logic [DATA_W-1:0]   alu_reg1_r, alu_reg1_nxt_s;
  logic [DATA_W-1:0]   alu_reg2_r, alu_reg2_nxt_s;
  logic [6:0]          alu_ld_sh_r, alu_ld_sh_nxt_s;
  logic                wb_en_r, wb_en_nxt_s;
  logic [ADDR_W-1:0]   wb_addr_r, wb_addr_nxt_s;
  logic [DATA_W-1:0]   wb_data_r, wb_data_nxt_s;
  logic                done_r, done_nxt_s;
  logic [3:0]          flags_r;
  logic                flag_upd_r, flag_upd_nxt_s;
  logic [3:0]          flag_new_r, flag_new_nxt_s;
  logic                pass_s;

  // Condition codes are tested against the architectural {N,Z,C,V}.
  function automatic logic cond_pass(input logic [1:0] cond, input logic [3:0] nzcv);
    logic ok;
    case (cond)
      2'b00:   ok = 1'b1;
      2'b01:   ok = nzcv[2];
      2'b10:   ok = ~nzcv[2];
      2'b11:   ok = nzcv[3];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return (op <= 4'd10);
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] op);
    logic sets;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd11: sets = 1'b1;
      default:                 sets = 1'b0;
    endcase
    return sets;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one accept, then a fixed READ/EXEC/WB walk.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (instr_valid) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = EXEC;
      EXEC:    state_nxt_s = WB;
      WB:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign pass_s = cond_pass(ir_r[15:14], flags_r);

  // Output logic: next values for every registered output and pipeline field.
  always_comb begin
    ir_nxt_s          = ir_r;
    instr_ready_nxt_s = (state_nxt_s == IDLE);
    alu_cond_nxt_s    = alu_cond_r;
    alu_op_nxt_s      = alu_op_r;
    alu_reg1_nxt_s    = alu_reg1_r;
    alu_reg2_nxt_s    = alu_reg2_r;
    alu_ld_sh_nxt_s   = alu_ld_sh_r;
    wb_en_nxt_s       = 1'b0;
    wb_addr_nxt_s     = {ADDR_W{1'b0}};
    wb_data_nxt_s     = {DATA_W{1'b0}};
    done_nxt_s        = 1'b0;
    flag_upd_nxt_s    = 1'b0;
    flag_new_nxt_s    = flag_new_r;
    case (state_r)
      IDLE: begin
        if (instr_valid) begin
          ir_nxt_s = instr;
        end else begin
          ir_nxt_s = ir_r;
        end
      end
      READ: begin
        alu_cond_nxt_s  = ir_r[15:14];
        alu_op_nxt_s    = ir_r[13:10];
        alu_reg1_nxt_s  = regs_r[ir_r[6:4]];
        alu_reg2_nxt_s  = regs_r[ir_r[3:1]];
        alu_ld_sh_nxt_s = ir_r[6:0];
      end
      EXEC: begin
        // WB outputs are registered, so the decision is taken as EXEC closes.
        done_nxt_s     = 1'b1;
        flag_new_nxt_s = alu_flags;
        flag_upd_nxt_s = pass_s & op_sets_flags(ir_r[13:10]);
        if (pass_s && op_writes(ir_r[13:10])) begin
          wb_en_nxt_s   = 1'b1;
          wb_addr_nxt_s = ir_r[9:7];
          wb_data_nxt_s = alu_result;
        end else begin
          wb_en_nxt_s   = 1'b0;
          wb_addr_nxt_s = {ADDR_W{1'b0}};
          wb_data_nxt_s = {DATA_W{1'b0}};
        end
      end
      WB: begin
        flag_new_nxt_s = flag_new_r;
      end
      default: begin
        ir_nxt_s = ir_r;
      end
    endcase
  end

  // Output and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r          <= 16'h0000;
      instr_ready_r <= 1'b1;
      alu_cond_r    <= 2'b00;
      alu_op_r      <= 4'b0000;
      alu_reg1_r    <= {DATA_W{1'b0}};
      alu_reg2_r    <= {DATA_W{1'b0}};
      alu_ld_sh_r   <= 7'b0000000;
      wb_en_r       <= 1'b0;
      wb_addr_r     <= {ADDR_W{1'b0}};
      wb_data_r     <= {DATA_W{1'b0}};
      done_r        <= 1'b0;
      flag_upd_r    <= 1'b0;
      flag_new_r    <= 4'b0000;
    end else begin
      ir_r          <= ir_nxt_s;
      instr_ready_r <= instr_ready_nxt_s;
      alu_cond_r    <= alu_cond_nxt_s;
      alu_op_r      <= alu_op_nxt_s;
      alu_reg1_r    <= alu_reg1_nxt_s;
      alu_reg2_r    <= alu_reg2_nxt_s;
      alu_ld_sh_r   <= alu_ld_sh_nxt_s;
      wb_en_r       <= wb_en_nxt_s;
      wb_addr_r     <= wb_addr_nxt_s;
      wb_data_r     <= wb_data_nxt_s;
      done_r        <= done_nxt_s;
      flag_upd_r    <= flag_upd_nxt_s;
      flag_new_r    <= flag_new_nxt_s;
    end
  end

  // Architectural state commits on the edge that closes WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      flags_r <= 4'b0000;
    end else begin
      if ((state_r == WB) && wb_en_r) begin
        regs_r[wb_addr_r] <= wb_data_r;
      end
      if ((state_r == WB) && flag_upd_r) begin
        flags_r <= flag_new_r;
      end
    end
  end

  assign instr_ready = instr_ready_r;
  assign alu_cond    = alu_cond_r;
  assign alu_op      = alu_op_r;
  assign alu_reg1    = alu_reg1_r;
  assign alu_reg2    = alu_reg2_r;
  assign alu_ld_sh   = alu_ld_sh_r;
  assign wb_en       = wb_en_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign done        = done_r;
  assign flags_out   = flags_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl paired with a small behavioural ALU.
// ALU flag convention: C on subtract/compare is "no borrow" (a >= b unsigned).
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [1:0]  alu_cond;
  logic [3:0]  alu_op;
  logic [15:0] alu_reg1;
  logic [15:0] alu_reg2;
  logic [6:0]  alu_ld_sh;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        done;
  logic [3:0]  flags_out;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_assert = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_cond(alu_cond), .alu_op(alu_op), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_ld_sh(alu_ld_sh), .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .done(done),
    .flags_out(flags_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real datapath.
  logic [16:0] sum17;
  logic [31:0] prod32;
  logic        alu_c, alu_v;
  always_comb begin
    sum17      = 17'd0;
    prod32     = 32'd0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_result = 16'd0;
    case (alu_op)
      4'd0: begin
        sum17      = {1'b0, alu_reg1} + {1'b0, alu_reg2};
        alu_result = sum17[15:0];
        alu_c      = sum17[16];
        alu_v      = (alu_reg1[15] == alu_reg2[15]) && (sum17[15] != alu_reg1[15]);
      end
      4'd1, 4'd11: begin
        sum17      = {1'b0, alu_reg1} + {1'b0, ~alu_reg2} + 17'd1;
        alu_result = sum17[15:0];
        alu_c      = sum17[16];
        alu_v      = (alu_reg1[15] != alu_reg2[15]) && (sum17[15] != alu_reg1[15]);
      end
      4'd2: begin
        prod32     = {16'd0, alu_reg1} * {16'd0, alu_reg2};
        alu_result = prod32[15:0];
      end
      4'd3:    alu_result = alu_reg1 & alu_reg2;
      4'd4:    alu_result = alu_reg1 | alu_reg2;
      4'd5:    alu_result = alu_reg1 ^ alu_reg2;
      4'd6:    alu_result = {9'd0, alu_ld_sh};
      4'd7:    alu_result = alu_reg1 << alu_ld_sh[3:0];
      4'd8:    alu_result = alu_reg1 >> alu_ld_sh[3:0];
      4'd9:    alu_result = ~alu_reg1;
      4'd10:   alu_result = alu_reg1;
      default: alu_result = 16'd0;
    endcase
  end
  assign alu_flags = {alu_result[15], (alu_result == 16'd0), alu_c, alu_v};

  function automatic logic [15:0] enc(input logic [1:0] c, input logic [3:0] op,
                                      input logic [2:0] rd, input logic [6:0] lo);
    return {c, op, rd, lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  // One full instruction with cycle-by-cycle checks; returns at a negedge in IDLE.
  task automatic run(input string tag, input logic [15:0] ins, input logic exp_wb,
                     input logic [2:0] exp_addr, input logic [15:0] exp_data,
                     input logic [15:0] exp_r1, input logic [15:0] exp_r2);
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    chk({tag, ".ready_idle"}, 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    @(negedge clk);
    chk({tag, ".ready_read"}, 32'(instr_ready), 32'd0);
    chk({tag, ".done_read"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, ".alu_cond"}, 32'(alu_cond), 32'(ins[15:14]));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(ins[13:10]));
    chk({tag, ".alu_reg1"}, 32'(alu_reg1), 32'(exp_r1));
    chk({tag, ".alu_reg2"}, 32'(alu_reg2), 32'(exp_r2));
    chk({tag, ".alu_ld_sh"}, 32'(alu_ld_sh), 32'(ins[6:0]));
    chk({tag, ".wb_en_exec"}, 32'(wb_en), 32'd0);
    chk({tag, ".done_exec"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, ".done_wb"}, 32'(done), 32'd1);
    chk({tag, ".wb_en_wb"}, 32'(wb_en), 32'(exp_wb));
    chk({tag, ".ready_wb"}, 32'(instr_ready), 32'd0);
    if (exp_wb) begin
      chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(exp_addr));
      chk({tag, ".wb_data"}, 32'(wb_data), 32'(exp_data));
    end
    @(negedge clk);
    chk({tag, ".done_after"}, 32'(done), 32'd0);
    chk({tag, ".wb_en_after"}, 32'(wb_en), 32'd0);
    chk({tag, ".ready_after"}, 32'(instr_ready), 32'd1);
    chk({tag, ".alu_op_hold"}, 32'(alu_op), 32'(ins[13:10]));
  endtask

  logic [15:0] q5 [3];
  int          acc [3];
  int          k;
  logic        acc_now;
  logic [13:0] rdy_seq;
  logic [15:0] got [$];

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 3'd0;
    #12;
    chk("rst.ready", 32'(instr_ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    chk("rst.wb_data", 32'(wb_data), 32'd0);
    chk("rst.flags", 32'(flags_out), 32'd0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    chk("rst.alu_reg1", 32'(alu_reg1), 32'd0);
    chk("rst.alu_ld_sh", 32'(alu_ld_sh), 32'd0);
    chk("rst.dbg", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MOVN R1,#5 (rs1 field=R0, rs2 field=R2, both 0)
    run("movn_r1", enc(2'd0, 4'd6, 3'd1, 7'd5), 1'b1, 3'd1, 16'd5, 16'd0, 16'd0);
    chk_reg("movn_r1.dbg", 3'd1, 16'd5);
    // ADD R2,R1,R1 = 10, flags 0000
    run("add_r2", enc(2'd0, 4'd0, 3'd2, {3'd1, 3'd1, 1'b0}), 1'b1, 3'd2, 16'd10, 16'd5, 16'd5);
    chk_reg("add_r2.dbg", 3'd2, 16'd10);
    chk("add_r2.flags", 32'(flags_out), 32'h0);
    // CMP R1,R1: no write, flags N0 Z1 C1 V0
    run("cmp", enc(2'd0, 4'd11, 3'd0, {3'd1, 3'd1, 1'b0}), 1'b0, 3'd0, 16'd0, 16'd5, 16'd5);
    chk("cmp.flags", 32'(flags_out), 32'h6);
    chk_reg("cmp.r0", 3'd0, 16'd0);
    // EQ MOVN R3,#7 passes
    run("eq_movn", enc(2'd1, 4'd6, 3'd3, 7'd7), 1'b1, 3'd3, 16'd7, 16'd0, 16'd0);
    chk_reg("eq_movn.dbg", 3'd3, 16'd7);
    // NE MOVN R4,#9 fails
    run("ne_movn", enc(2'd2, 4'd6, 3'd4, 7'd9), 1'b0, 3'd0, 16'd0, 16'd0, 16'd0);
    chk_reg("ne_movn.dbg", 3'd4, 16'd0);
    // NOP (op 1100) with Z=1: nothing changes
    run("nop", enc(2'd0, 4'd12, 3'd1, {3'd1, 3'd1, 1'b0}), 1'b0, 3'd0, 16'd0, 16'd5, 16'd5);
    chk("nop.flags", 32'(flags_out), 32'h6);
    chk_reg("nop.r1", 3'd1, 16'd5);
    chk_reg("nop.r2", 3'd2, 16'd10);
    // SUB R4,R4,R1 = 0-5 = FFFB, flags N1 Z0 C0 V0
    run("sub_r4", enc(2'd0, 4'd1, 3'd4, {3'd4, 3'd1, 1'b0}), 1'b1, 3'd4, 16'hFFFB, 16'd0, 16'd5);
    chk("sub_r4.flags", 32'(flags_out), 32'h8);
    chk_reg("sub_r4.dbg", 3'd4, 16'hFFFB);
    // MI MOVN R6,#3 passes (N=1); rs2 field = R1
    run("mi_movn", enc(2'd3, 4'd6, 3'd6, 7'd3), 1'b1, 3'd6, 16'd3, 16'd0, 16'd5);
    chk_reg("mi_movn.dbg", 3'd6, 16'd3);

    // Back-to-back: valid held high for three instructions
    q5[0] = enc(2'd0, 4'd6, 3'd5, 7'd1);
    q5[1] = enc(2'd0, 4'd6, 3'd7, 7'd2);
    q5[2] = enc(2'd0, 4'd1, 3'd0, {3'd5, 3'd7, 1'b0});
    k = 0;
    rdy_seq = 14'd0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    @(negedge clk);
    instr       = q5[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      rdy_seq[c] = instr_ready;
      if (done && wb_en) got.push_back(wb_data);
      acc_now = instr_valid && instr_ready;
      if (acc_now) acc[k] = c;
      @(posedge clk);
      #1;
      if (acc_now) begin
        k++;
        if (k < 3) instr = q5[k];
        else instr_valid = 1'b0;
      end
    end
    chk("b2b.accepts", 32'(k), 32'd3);
    chk("b2b.gap01", 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b.gap12", 32'(acc[2] - acc[1]), 32'd4);
    chk("b2b.ready_seq", 32'(rdy_seq), 32'h3111);
    chk("b2b.nwb", 32'(got.size()), 32'd3);
    chk("b2b.res0", 32'(got.size() > 0 ? got[0] : 16'hDEAD), 32'd1);
    chk("b2b.res1", 32'(got.size() > 1 ? got[1] : 16'hDEAD), 32'd2);
    chk("b2b.res2", 32'(got.size() > 2 ? got[2] : 16'hDEAD), 32'hFFFF);
    chk("b2b.flags", 32'(flags_out), 32'h8);
    chk_reg("b2b.r0", 3'd0, 16'hFFFF);

    // Reset during EXEC of ADD R2,R1,R3
    @(negedge clk);
    instr       = enc(2'd0, 4'd0, 3'd2, {3'd1, 3'd3, 1'b0});
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst6.reg1_exec", 32'(alu_reg1), 32'd5);
    chk("rst6.reg2_exec", 32'(alu_reg2), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst6.ready", 32'(instr_ready), 32'd1);
    chk("rst6.flags", 32'(flags_out), 32'd0);
    chk("rst6.alu_reg1", 32'(alu_reg1), 32'd0);
    chk("rst6.done", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk_reg($sformatf("rst6.r%0d", i), 3'(i), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst6.idle_wb%0d", i), 32'(wb_en), 32'd0);
      chk($sformatf("rst6.idle_rdy%0d", i), 32'(instr_ready), 32'd1);
    end
    chk_reg("rst6.r2_after", 3'd2, 16'd0);

    // Normal operation resumes after reset
    run("post_rst", enc(2'd0, 4'd6, 3'd2, 7'd4), 1'b1, 3'd2, 16'd4, 16'd0, 16'd0);
    chk_reg("post_rst.dbg", 3'd2, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
